// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset/exception vectors,
// next-PC selection codes and fetch state encodings.
package ifu_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   typedef enum logic [2:0] {
      NPC_PLUS4  = 3'd0,
      NPC_BRANCH = 3'd1,
      NPC_JUMP   = 3'd2,
      NPC_JR     = 3'd3,
      NPC_EXCEPT = 3'd4
   } npc_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      EXEC  = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ifu_npc_calc.sv
// Combinational next-PC computation; exc_o flags any selection that
// redirects to the exception vector, including a misaligned JR target.
module npc_calc (
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic [2:0]  npc_op_i,
   input  logic [31:0] rs_data_i,
   output logic [31:0] npc_o,
   output logic        exc_o
);
   import ifu_pkg::*;

   logic [31:0] p4;
   logic [31:0] branchOff;

   assign p4        = pc_i + 32'd4;
   assign branchOff = {{14{ir_i[15]}}, ir_i[15:0], 2'b00};

   // Unused codes 5-7 fall through to the sequential PC.
   always_comb begin
      npc_o = p4;
      exc_o = 1'b0;
      case (npc_op_i)
         NPC_BRANCH: npc_o = p4 + branchOff;
         NPC_JUMP:   npc_o = {p4[31:28], ir_i[25:0], 2'b00};
         NPC_JR: begin
            if (rs_data_i[1:0] != 2'b00) begin
               npc_o = EXC_VECTOR;
               exc_o = 1'b1;
            end else begin
               npc_o = rs_data_i;
            end
         end
         NPC_EXCEPT: begin
            npc_o = EXC_VECTOR;
            exc_o = 1'b1;
         end
         default: npc_o = p4;
      endcase
   end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a req/gnt/rvalid handshake
// and applies the decoder's next-PC selection. Optional EPC register: IFU_EPC_EN.
module ifu (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  npc_op,
   input  logic [31:0] rs_data,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        nop,
   output logic [31:0] epc
);
   import ifu_pkg::*;

   ifu_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] npc;
   logic        exc;

   npc_calc u_npc_calc (
      .pc_i      (pc_q),
      .ir_i      (ir_q),
      .npc_op_i  (npc_op),
      .rs_data_i (rs_data),
      .npc_o     (npc),
      .exc_o     (exc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // rvalid is only honoured while a fetch is outstanding (FETCH or WAIT).
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imem_req = 1'b0;
      nop      = 1'b1;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_gnt) begin
               if (imem_rvalid) begin
                  ir_d    = imem_rdata;
                  state_d = EXEC;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               ir_d    = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            nop = 1'b0;
            if (!stall) begin
               pc_d    = npc;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = ir_q;

`ifdef IFU_EPC_EN
   logic [31:0] epc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_q <= '0;
      end else if (state_q == EXEC && !stall && exc) begin
         epc_q <= pc_q;
      end
   end

   assign epc = epc_q;
`else
   assign epc = '0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a memory model with configurable grant/valid
// latency, and queues of expected fetch addresses and instruction words.
module tb_ifu;

   logic        clk;
   logic        rst;
   logic [2:0]  npc_op;
   logic [31:0] rs_data;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        nop;
   logic [31:0] epc;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] addrQ[$];
   logic [31:0] instrQ[$];
   logic [31:0] expEpc;

   ifu dut (
      .clk         (clk),
      .rst         (rst),
      .npc_op      (npc_op),
      .rs_data     (rs_data),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .pc          (pc),
      .nop         (nop),
      .epc         (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a wedged DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference next-PC rule, written from the architectural description.
   function automatic logic [31:0] modelNpc(input logic [31:0] curPc, input logic [31:0] ir,
                                            input logic [2:0] op, input logic [31:0] rs,
                                            output logic takesExc);
      logic [31:0] seq;
      logic [31:0] off;
      seq      = curPc + 32'd4;
      off      = {{16{ir[15]}}, ir[15:0]} << 2;
      takesExc = 1'b0;
      case (op)
         3'd1: return seq + off;
         3'd2: return (seq & 32'hF000_0000) | ({6'd0, ir[25:0]} << 2);
         3'd3: begin
            if (rs % 4 != 0) begin
               takesExc = 1'b1;
               return 32'h0000_4180;
            end
            return rs;
         end
         3'd4: begin
            takesExc = 1'b1;
            return 32'h0000_4180;
         end
         default: return seq;
      endcase
   endfunction

   // One full instruction: wait for the request, answer with the given
   // latencies, hold EXEC for stallCycles, then apply op and check the new PC.
   task automatic applyStimulus(input logic [31:0] word, input int gntDelay, input int rvDelay,
                                input int stallCycles, input logic [2:0] op, input logic [31:0] rs);
      int          n;
      logic [31:0] expAddr;
      logic [31:0] nextPc;
      logic        exc;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (imem_req !== 1'b1) begin
         checkOutput("reqTimeout", {31'd0, imem_req}, 32'd1);
         return;
      end
      if (addrQ.size() == 0) begin
         checkOutput("addrQEmpty", 32'd0, 32'd1);
         return;
      end
      expAddr = addrQ.pop_front();
      checkOutput("fetchAddr", imem_addr, expAddr);
      for (int i = 0; i < gntDelay; i++) begin
         tick();
         checkOutput("reqHeld", {31'd0, imem_req}, 32'd1);
      end
      imem_gnt = 1'b1;
      if (rvDelay == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word;
      end
      instrQ.push_back(word);
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (rvDelay > 0) begin
         for (int i = 0; i < rvDelay - 1; i++) begin
            checkOutput("waitNoReq", {31'd0, imem_req}, 32'd0);
            tick();
         end
         checkOutput("waitNoReq", {31'd0, imem_req}, 32'd0);
         imem_rvalid = 1'b1;
         imem_rdata  = word;
         tick();
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      checkOutput("execNop", {31'd0, nop}, 32'd0);
      checkOutput("execInstr", instr, instrQ.pop_front());
      checkOutput("execPc", pc, expAddr);
      stall  = 1'b1;
      npc_op = 3'd4;
      for (int i = 0; i < stallCycles; i++) begin
         tick();
         checkOutput("stallPc", pc, expAddr);
         checkOutput("stallInstr", instr, word);
         checkOutput("stallNop", {31'd0, nop}, 32'd0);
      end
      stall   = 1'b0;
      npc_op  = op;
      rs_data = rs;
      nextPc  = modelNpc(expAddr, word, op, rs, exc);
      addrQ.push_back(nextPc);
`ifdef IFU_EPC_EN
      if (exc) expEpc = expAddr;
`endif
      tick();
      npc_op  = 3'($urandom_range(0, 7));
      rs_data = $urandom;
      checkOutput("postNop", {31'd0, nop}, 32'd1);
      checkOutput("newPc", pc, nextPc);
      checkOutput("epc", epc, expEpc);
   endtask

   initial begin
      rst         = 1'b1;
      npc_op      = 3'd0;
      rs_data     = '0;
      stall       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      expEpc      = '0;
      tick();
      tick();
      checkOutput("rstPc", pc, 32'h3000);
      checkOutput("rstAddr", imem_addr, 32'h3000);
      checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
      checkOutput("rstNop", {31'd0, nop}, 32'd1);
      checkOutput("rstInstr", instr, 32'd0);
      checkOutput("rstEpc", epc, 32'd0);
      rst = 1'b0;
      checkOutput("idleReq", {31'd0, imem_req}, 32'd0);
      tick();
      checkOutput("firstReq", {31'd0, imem_req}, 32'd1);
      addrQ.push_back(32'h3000);

      applyStimulus(32'h2008_0005, 0, 0, 0, 3'd0, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(32'h0000_0000, 0, 1, 0, 3'd0, 32'd0);
      applyStimulus(32'h1000_FFFC, 0, 0, 0, 3'd1, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(32'h0000_0000, 0, 0, 0, 3'd0, 32'd0);
      applyStimulus(32'h1000_0002, 0, 1, 0, 3'd1, 32'd0);
      applyStimulus(32'h0000_0000, 0, 0, 0, 3'd0, 32'd0);
      applyStimulus(32'h0800_0C10, 0, 0, 0, 3'd2, 32'd0);
      applyStimulus(32'h0000_0008, 0, 0, 0, 3'd3, 32'h0000_3100);
      applyStimulus(32'h0000_0008, 0, 0, 0, 3'd3, 32'h0000_3102);
      applyStimulus(32'h1234_5678, 2, 3, 4, 3'd4, 32'd0);
      applyStimulus(32'h0000_0000, 1, 0, 2, 3'd5, 32'd0);

      // Reset during WAIT, then a stale rvalid right after release.
      while (imem_req !== 1'b1 && checks < 100000) tick();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      checkOutput("inWait", {31'd0, imem_req}, 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("midRstPc", pc, 32'h3000);
      checkOutput("midRstNop", {31'd0, nop}, 32'd1);
      checkOutput("midRstInstr", instr, 32'd0);
      expEpc = '0;
      checkOutput("midRstEpc", epc, expEpc);
      tick();
      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      checkOutput("staleInstr", instr, 32'd0);
      checkOutput("staleNop", {31'd0, nop}, 32'd1);
      checkOutput("restartReq", {31'd0, imem_req}, 32'd1);
      checkOutput("restartAddr", imem_addr, 32'h3000);
      addrQ.delete();
      instrQ.delete();
      addrQ.push_back(32'h3000);
      applyStimulus(32'h2008_0005, 0, 0, 0, 3'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit that owns the program counter, fetches each instruction from instruction memory over a request/grant/valid handshake, and presents it to the control decoder. The decoder returns a next-PC selection (`npc_op`) for the presented instruction. The block applies that selection and fetches the next instruction. It sits between instruction memory and the control/datapath as the responder to the decoder's NPC selection. While no valid instruction is held, it drives `nop` so the decoder emits bubble controls.

## Interface
- `RESET_PC`, 32'h0000_3000: PC loaded on reset.
- `EXC_VECTOR`, 32'h0000_4180: PC loaded on the EXCEPT selection or a misaligned JR target.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `npc_op`  in  3  next-PC selection for the presented instruction: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 EXCEPT; codes 5–7 behave as PLUS4.
- `rs_data`  in  32  register rs value, used as the JR target.
- `stall`  in  1  downstream hold; freezes the EXEC state.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (equals `pc`).
- `imem_gnt`  in  1  memory accepted the request.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register contents.
- `pc`  out  32  address of the presented instruction.
- `nop`  out  1  high when `instr` is not a valid instruction for execution.
- `epc`  out  32  PC of the last instruction that took EXCEPT (see Configuration).

## Operation
- States are IDLE, FETCH, WAIT and EXEC. IDLE is the reset state.
- **IDLE:** `imem_req`=0. Moves to FETCH on the next clock.
- **FETCH:** `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_gnt`=0: stay in FETCH.
  - `imem_gnt`=1 and `imem_rvalid`=0: go to WAIT.
  - `imem_gnt`=1 and `imem_rvalid`=1 in the same cycle: capture `imem_rdata` into IR and go to EXEC.
- **WAIT:** `imem_req`=0. Stay until `imem_rvalid`=1, then capture IR and go to EXEC.
- **EXEC:** `nop`=0 (`nop`=1 in every other state).
  - `stall`=1: hold PC, IR and state.
  - `stall`=0: load PC with the next PC and go to FETCH.
- Next-PC rules. All arithmetic is 32-bit modulo 2^32 with no overflow flag. `p4` = `pc`+4.
  - PLUS4: `p4`.
  - BRANCH: `p4` + {sext(IR[15:0]), 2'b00}.
  - JUMP: {`p4`[31:28], IR[25:0], 2'b00}.
  - JR: `rs_data`. If `rs_data`[1:0]≠0, the target is `EXC_VECTOR` and the event is treated as EXCEPT.
  - EXCEPT: `EXC_VECTOR`.
- `npc_op` is sampled only in EXEC with `stall`=0; it is ignored in all other states.
- `imem_rvalid` arriving outside FETCH or WAIT is ignored.

## Timing
- Reset values: PC=`RESET_PC`, IR=0, state IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0, `pc`=`RESET_PC`, `nop`=1, `epc`=0.
- Reset asserted mid-fetch aborts immediately. A late `imem_rvalid` after reset release is ignored, because the state is IDLE.
- Zero-wait memory (gnt and rvalid in the same cycle) gives 2 cycles per instruction: FETCH, EXEC.
- Memory with gnt then rvalid one cycle later gives 3 cycles per instruction: FETCH, WAIT, EXEC.
- The first `imem_req` is asserted in the second cycle after `rst` falls.
- The new PC is visible on `pc` and `imem_addr` in the cycle after the EXEC exit edge.

## Configuration
- `IFU_EPC_EN` defined:
  - A 32-bit EPC register loads `pc` on every EXCEPT or misaligned JR taken in EXEC.
  - It holds otherwise and resets to 0.
  - It drives `epc`.
- `IFU_EPC_EN` undefined: no EPC register; `epc` is tied to 0. All other behaviour is identical.

## Structure
- Shared package/include holds:
  - NPC op codes (NPC_PLUS4=0, NPC_BRANCH=1, NPC_JUMP=2, NPC_JR=3, NPC_EXCEPT=4).
  - IFU state encodings (IDLE=0, FETCH=1, WAIT=2, EXEC=3).
- One combinational sub-module, `npc_calc`, computes the next PC and the misalign flag.
  - Inputs: pc, IR, npc_op, rs_data.
  - Outputs: npc, exc.

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005 at 32'h3000, `npc_op`=0 → `nop` low in EXEC with `instr`=32'h2008_0005; next `imem_addr`=32'h3004.
- Branch: PC=32'h3010, IR[15:0]=16'hFFFC, `npc_op`=1 → next PC=32'h3004. Repeat with IR[15:0]=16'h0002 → next PC=32'h301C.
- Jump at PC=32'h3020 with IR[25:0]=26'h0000_C10 → next PC=32'h0000_3040. JR with `rs_data`=32'h3100 → next PC=32'h3100.
- JR with `rs_data`=32'h3102 → next PC=32'h4180. With `IFU_EPC_EN` defined, `epc` equals the JR's PC; without it, `epc`=0.
- Memory with gnt delayed 2 cycles and rvalid 3 cycles after gnt, plus `stall` high for 4 cycles in EXEC → `imem_req` held until gnt; PC and `instr` stable during the stall; exactly one PC update.
- Assert `rst` while in WAIT, then pulse `imem_rvalid` with 32'hDEAD_BEEF after release → IR stays 0, `nop`=1, and the fetch restarts at 32'h3000.
